// File: rtl/m_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory request in flight,
// and delivers {pc, inst, next_pc} through a one-entry output register. Define IF_PERF_CNT_EN to add fetch/flush counters.
module m_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 6,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  input  logic               w_stall,
  input  logic               w_redirect,
  input  logic [31:0]        w_redirect_pc,
  output logic               w_imem_req,
  output logic [IMEM_AW-1:0] w_imem_addr,
  input  logic               w_imem_gnt,
  input  logic               w_imem_rvalid,
  input  logic [31:0]        w_imem_rdata,
  output logic               w_if_valid,
  output logic [31:0]        w_if_pc,
  output logic [31:0]        w_if_inst,
  output logic [31:0]        w_if_next_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        w_perf_fetched,
  output logic [31:0]        w_perf_flushed
`endif
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_next_pc_q, if_next_pc_d;
  logic        slot_free;
  logic        redirect_pc_unused;

  // Target alignment discards the byte offset of the redirect address.
  assign redirect_pc_unused = ^w_redirect_pc[1:0];

  assign slot_free   = ~if_valid_q | ~w_stall;
  assign w_imem_req  = (state_q == S_REQ) & slot_free & ~w_redirect;
  assign w_imem_addr = pc_q[IMEM_AW+1:2];

  assign w_if_valid   = if_valid_q;
  assign w_if_pc      = if_pc_q;
  assign w_if_inst    = if_inst_q;
  assign w_if_next_pc = if_next_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_next_pc_d = if_next_pc_q;

    if (if_valid_q && !w_stall) begin
      if_valid_d = 1'b0;
    end

    if (w_redirect) begin
      pc_d       = {w_redirect_pc[31:2], 2'b00};
      if_valid_d = 1'b0;
      if_inst_d  = NOP_INST;
      if (state_q == S_WAIT) begin
        // A response arriving now is the wrong-path one; otherwise remember to drop it.
        if (w_imem_rvalid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end else begin
          drop_d  = 1'b1;
        end
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (w_imem_req && w_imem_gnt) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_imem_rvalid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
            if (!drop_q) begin
              if_valid_d   = 1'b1;
              if_pc_d      = pc_q;
              if_inst_d    = w_imem_rdata;
              if_next_pc_d = pc_q + 32'd4;
              pc_d         = pc_q + 32'd4;
            end
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'd0;
      if_inst_q    <= NOP_INST;
      if_next_pc_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      if_next_pc_q <= if_next_pc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // A redirect counts once as a flush if it kills a live output or any in-flight response.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (!w_redirect && (state_q == S_WAIT) && w_imem_rvalid && !drop_q) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (w_redirect && (if_valid_q || (state_q == S_WAIT))) begin
      perf_flushed_d = perf_flushed_q + 32'd1;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_flushed_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign w_perf_fetched = perf_fetched_q;
  assign w_perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_m_fetch_stage.sv
// Bench for m_fetch_stage: directed vector table, randomized run against a program-order model,
// and a second instance exercising PC wrap and asynchronous reset.
module tb_m_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h00A0_0113;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, stall0, redir0, gnt0, rvalid0;
  logic [31:0] rpc0, rdata0;
  logic        req0, valid0;
  logic [5:0]  addr0;
  logic [31:0] pc0, inst0, npc0;

  logic        rst1_n, stall1, redir1, gnt1, rvalid1;
  logic [31:0] rpc1, rdata1;
  logic        req1, valid1;
  logic [5:0]  addr1;
  logic [31:0] pc1, inst1, npc1;

`ifdef IF_PERF_CNT_EN
  logic [31:0] pf0_fetched, pf0_flushed, pf1_fetched, pf1_flushed;
`endif

  m_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(6), .NOP_INST(NOP)) dut0 (
    .w_clk(clk), .w_rst_n(rst0_n), .w_stall(stall0), .w_redirect(redir0),
    .w_redirect_pc(rpc0), .w_imem_req(req0), .w_imem_addr(addr0),
    .w_imem_gnt(gnt0), .w_imem_rvalid(rvalid0), .w_imem_rdata(rdata0),
    .w_if_valid(valid0), .w_if_pc(pc0), .w_if_inst(inst0), .w_if_next_pc(npc0)
`ifdef IF_PERF_CNT_EN
    , .w_perf_fetched(pf0_fetched), .w_perf_flushed(pf0_flushed)
`endif
  );

  m_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(6), .NOP_INST(NOP)) dut1 (
    .w_clk(clk), .w_rst_n(rst1_n), .w_stall(stall1), .w_redirect(redir1),
    .w_redirect_pc(rpc1), .w_imem_req(req1), .w_imem_addr(addr1),
    .w_imem_gnt(gnt1), .w_imem_rvalid(rvalid1), .w_imem_rdata(rdata1),
    .w_if_valid(valid1), .w_if_pc(pc1), .w_if_inst(inst1), .w_if_next_pc(npc1)
`ifdef IF_PERF_CNT_EN
    , .w_perf_fetched(pf1_fetched), .w_perf_flushed(pf1_flushed)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];
  int          mem_cnt;
  logic [5:0]  mem_addr;
  int          lat;

  typedef struct {
    logic gnt; int lat; logic stall; logic redir; logic [31:0] rpc;
    logic req; logic [5:0] addr; logic valid; logic chk;
    logic [31:0] pc; logic [31:0] inst; logic [31:0] npc;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic g, int l, logic s, logic r, logic [31:0] rp,
                              logic q, logic [5:0] a, logic v, logic c,
                              logic [31:0] p, logic [31:0] ins, logic [31:0] np);
    vec_t x;
    x.gnt = g; x.lat = l; x.stall = s; x.redir = r; x.rpc = rp;
    x.req = q; x.addr = a; x.valid = v; x.chk = c;
    x.pc = p; x.inst = ins; x.npc = np;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One clock of dut0 with the instruction-memory model: a grant launches a response lat cycles later.
  task automatic tick0();
    logic       p_req, p_gnt;
    logic [5:0] p_addr;
    p_req = req0; p_gnt = gnt0; p_addr = addr0;
    @(posedge clk);
    #1;
    if (mem_cnt > 0) mem_cnt--;
    if (rst0_n && p_req && p_gnt) begin
      mem_cnt  = lat;
      mem_addr = p_addr;
    end
    rvalid0 = (mem_cnt == 1);
    rdata0  = rvalid0 ? mem[mem_addr] : 32'hBAD0_BAD0;
  endtask

  logic [31:0] m_pc;
  int          delivered;
  logic        p_valid, p_stall, p_redir;
  logic [31:0] p_rpc, p_pc, p_inst;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | i;
    mem[0] = I0;
    mem[1] = I1;
    mem_cnt = 0; mem_addr = '0; lat = 1;
    rst0_n = 1'b0; stall0 = 1'b0; redir0 = 1'b0; gnt0 = 1'b1; rpc0 = '0; rvalid0 = 1'b0; rdata0 = '0;
    rst1_n = 1'b0; stall1 = 1'b0; redir1 = 1'b0; gnt1 = 1'b0; rpc1 = '0; rvalid1 = 1'b0; rdata1 = '0;

    // gnt lat stall redir rpc | req addr valid chk pc inst next_pc
    vt.push_back(mk(1,1,0,0,0,        1,6'h00,0,1, 32'h0, NOP, 32'h0));
    vt.push_back(mk(1,1,0,0,0,        0,6'h00,0,0, 0,0,0));
    vt.push_back(mk(1,1,0,0,0,        1,6'h01,1,1, 32'h0, I0, 32'h4));
    vt.push_back(mk(1,1,0,0,0,        0,6'h01,0,0, 0,0,0));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1,1,1,0,0,      0,6'h02,1,1, 32'h4, I1, 32'h8));
    vt.push_back(mk(1,2,0,0,0,        1,6'h02,1,1, 32'h4, I1, 32'h8));
    vt.push_back(mk(1,1,0,1,32'h40,   0,6'h02,0,0, 0,0,0));
    vt.push_back(mk(1,1,0,0,0,        0,6'h10,0,1, 32'h4, NOP, 32'h8));
    vt.push_back(mk(1,1,0,0,0,        1,6'h10,0,0, 0,0,0));
    vt.push_back(mk(1,1,0,0,0,        0,6'h10,0,0, 0,0,0));
    vt.push_back(mk(1,1,0,0,0,        1,6'h11,1,1, 32'h40, 32'hC000_0010, 32'h44));
    vt.push_back(mk(1,1,0,1,32'h23,   0,6'h11,0,0, 0,0,0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,0,0,0,      1,6'h08,0,0, 0,0,0));
    vt.push_back(mk(1,1,0,0,0,        1,6'h08,0,0, 0,0,0));
    vt.push_back(mk(0,1,0,0,0,        0,6'h08,0,0, 0,0,0));
    vt.push_back(mk(0,1,1,1,32'h80,   0,6'h09,1,1, 32'h20, 32'hC000_0008, 32'h24));
    vt.push_back(mk(0,1,0,0,0,        1,6'h20,0,1, 32'h20, NOP, 32'h24));

    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      gnt0 = vt[i].gnt; lat = vt[i].lat; stall0 = vt[i].stall;
      redir0 = vt[i].redir; rpc0 = vt[i].rpc;
      #3;
      chk($sformatf("vec%0d req", i), {31'd0, req0}, {31'd0, vt[i].req});
      chk($sformatf("vec%0d addr", i), {26'd0, addr0}, {26'd0, vt[i].addr});
      chk($sformatf("vec%0d valid", i), {31'd0, valid0}, {31'd0, vt[i].valid});
      if (vt[i].chk) begin
        chk($sformatf("vec%0d pc", i), pc0, vt[i].pc);
        chk($sformatf("vec%0d inst", i), inst0, vt[i].inst);
        chk($sformatf("vec%0d next_pc", i), npc0, vt[i].npc);
      end
      tick0();
    end

    // Randomized run: deliveries must follow program order from the last redirect.
    gnt0 = 1'b0; stall0 = 1'b0; redir0 = 1'b0; rst0_n = 1'b0;
    mem_cnt = 0; rvalid0 = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    #3;
    chk("rand reset valid", {31'd0, valid0}, 32'd0);
    chk("rand reset inst", inst0, NOP);
    tick0();
    rst0_n = 1'b1;
    m_pc = 32'h0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      gnt0   = ($urandom_range(99) < 70);
      stall0 = ($urandom_range(99) < 30);
      redir0 = ($urandom_range(99) < 6);
      rpc0   = $urandom();
      lat    = $urandom_range(3, 1);
      #3;
      if (req0) begin
        chk($sformatf("rand c%0d addr", c), {26'd0, addr0}, {26'd0, m_pc[7:2]});
        chk($sformatf("rand c%0d outstanding", c), mem_cnt, 0);
      end
      if (redir0 || (valid0 && stall0))
        chk($sformatf("rand c%0d req_blocked", c), {31'd0, req0}, 32'd0);
      p_valid = valid0; p_stall = stall0; p_redir = redir0;
      p_rpc = rpc0; p_pc = pc0; p_inst = inst0;
      tick0();
      if (p_redir) begin
        chk($sformatf("rand c%0d flush_valid", c), {31'd0, valid0}, 32'd0);
        m_pc = {p_rpc[31:2], 2'b00};
      end else if (p_valid && p_stall) begin
        chk($sformatf("rand c%0d hold_valid", c), {31'd0, valid0}, 32'd1);
        chk($sformatf("rand c%0d hold_pc", c), pc0, p_pc);
        chk($sformatf("rand c%0d hold_inst", c), inst0, p_inst);
      end else if (valid0) begin
        chk($sformatf("rand c%0d pc", c), pc0, m_pc);
        chk($sformatf("rand c%0d inst", c), inst0, mem[m_pc[7:2]]);
        chk($sformatf("rand c%0d next_pc", c), npc0, m_pc + 32'd4);
        m_pc = m_pc + 32'd4;
        delivered++;
      end
    end
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL rand liveness: got %0d deliveries expected at least 100", delivered);
    end

    // Second instance: PC wrap at the top of the address space and asynchronous reset.
    @(posedge clk);
    #1;
    rst1_n = 1'b1; gnt1 = 1'b1;
    #3;
    chk("wrap req", {31'd0, req1}, 32'd1);
    chk("wrap addr", {26'd0, addr1}, 32'h3F);
    @(posedge clk);
    #1;
    gnt1 = 1'b0; rvalid1 = 1'b1; rdata1 = 32'hDEAD_BEEF;
    #3;
    chk("wrap wait req", {31'd0, req1}, 32'd0);
    @(posedge clk);
    #1;
    rvalid1 = 1'b0;
    #3;
    chk("wrap valid", {31'd0, valid1}, 32'd1);
    chk("wrap pc", pc1, 32'hFFFF_FFFC);
    chk("wrap inst", inst1, 32'hDEAD_BEEF);
    chk("wrap next_pc", npc1, 32'h0);
    chk("wrap next addr", {26'd0, addr1}, 32'h0);
    gnt1 = 1'b1;
    @(posedge clk);
    #1;
    gnt1 = 1'b0;
    #1;
    rst1_n = 1'b0;
    #1;
    chk("areset valid", {31'd0, valid1}, 32'd0);
    chk("areset pc", pc1, 32'h0);
    chk("areset inst", inst1, NOP);
    chk("areset next_pc", npc1, 32'h0);
    chk("areset addr", {26'd0, addr1}, 32'h3F);
    @(posedge clk);
    #1;
    rst1_n = 1'b1; rvalid1 = 1'b1; rdata1 = 32'h1234_5678;
    @(posedge clk);
    #1;
    rvalid1 = 1'b0;
    #3;
    chk("stale valid", {31'd0, valid1}, 32'd0);
    chk("stale req", {31'd0, req1}, 32'd1);
    chk("stale addr", {26'd0, addr1}, 32'h3F);
    gnt1 = 1'b1;
    @(posedge clk);
    #1;
    gnt1 = 1'b0; rvalid1 = 1'b1; rdata1 = 32'h0000_0113;
    @(posedge clk);
    #1;
    rvalid1 = 1'b0;
    #3;
    chk("post-reset valid", {31'd0, valid1}, 32'd1);
    chk("post-reset pc", pc1, 32'hFFFF_FFFC);
    chk("post-reset inst", inst1, 32'h0000_0113);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
